regfile_wb_arbiter: RTL and testbench

REGFILE_WB_ARBITER -- requirements
Module: regfile_wb_arbiter

---
 rtl/regfile_wb_arbiter_if.sv | 32 +++
 rtl/regfile_wb_arbiter.sv | 108 ++++++++++
 tb/tb_regfile_wb_arbiter.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/regfile_wb_arbiter_if.sv
// Bundle of the writeback arbiter's bus signals: pipeline request, long-latency
// result stream, register-file write port and FIFO status.
interface regfile_wb_arbiter_if #(
   parameter int DEPTH = 4
);
   logic                     i_pipe_valid;
   logic [4:0]               i_pipe_addr;
   logic [31:0]              i_pipe_data;
   logic                     o_pipe_stall;
   logic                     i_ll_valid;
   logic                     o_ll_ready;
   logic [4:0]               i_ll_addr;
   logic [31:0]              i_ll_data;
   logic                     o_write;
   logic [4:0]               o_write_addr;
   logic [31:0]              o_write_data;
   logic [$clog2(DEPTH):0]   o_fifo_count;

   modport slave (
      input  i_pipe_valid, i_pipe_addr, i_pipe_data,
      input  i_ll_valid, i_ll_addr, i_ll_data,
      output o_pipe_stall, o_ll_ready,
      output o_write, o_write_addr, o_write_data, o_fifo_count
   );

   modport master (
      output i_pipe_valid, i_pipe_addr, i_pipe_data,
      output i_ll_valid, i_ll_addr, i_ll_data,
      input  o_pipe_stall, o_ll_ready,
      input  o_write, o_write_addr, o_write_data, o_fifo_count
   );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// Register-file writeback arbiter: pipeline writes win the single write port,
// long-latency results queue in an in-order FIFO and force a stall when starved.
module regfile_wb_arbiter #(
   parameter int DEPTH    = 4,
   parameter int MAX_WAIT = 8
) (
   input  logic                  clk,
   input  logic                  rst_n,
   regfile_wb_arbiter_if.slave   bus
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam int WW = $clog2(MAX_WAIT + 1);
   localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
   localparam logic [WW-1:0] WAIT_MAX = WW'(MAX_WAIT);

   logic [4:0]    r_mem_addr [DEPTH];
   logic [31:0]   r_mem_data [DEPTH];
   logic [AW-1:0] r_wr_ptr;
   logic [AW-1:0] r_rd_ptr;
   logic [CW-1:0] r_count;
   logic [WW-1:0] r_wait;
   logic          r_stall;
   logic          r_write;
   logic [4:0]    r_write_addr;
   logic [31:0]   r_write_data;

   logic          w_nonempty;
   logic          w_ready;
   logic          w_pipe_req;
   logic          w_pop;
   logic          w_push;
   logic [CW-1:0] w_count_nxt;
   logic [WW-1:0] w_wait_nxt;

   // Arbitration, FIFO handshake and next-state of count and wait counter
   always_comb begin
      w_nonempty = (r_count != {CW{1'b0}});
      w_ready    = (r_count < FULL_CNT);
      w_pipe_req = bus.i_pipe_valid && (bus.i_pipe_addr != 5'd0) && !r_stall;
      w_pop      = !w_pipe_req && w_nonempty;
      w_push     = bus.i_ll_valid && w_ready && (bus.i_ll_addr != 5'd0);

      case ({w_push, w_pop})
         2'b10:   w_count_nxt = r_count + CW'(1);
         2'b01:   w_count_nxt = r_count - CW'(1);
         default: w_count_nxt = r_count;
      endcase

      if (w_pop || !w_nonempty) begin
         w_wait_nxt = {WW{1'b0}};
      end else if (r_wait == WAIT_MAX) begin
         w_wait_nxt = r_wait;
      end else begin
         w_wait_nxt = r_wait + WW'(1);
      end
   end

   // FIFO storage, pointers, starvation tracking and the registered write port
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            r_mem_addr[i] <= 5'd0;
            r_mem_data[i] <= 32'd0;
         end
         r_wr_ptr     <= {AW{1'b0}};
         r_rd_ptr     <= {AW{1'b0}};
         r_count      <= {CW{1'b0}};
         r_wait       <= {WW{1'b0}};
         r_stall      <= 1'b0;
         r_write      <= 1'b0;
         r_write_addr <= 5'd0;
         r_write_data <= 32'd0;
      end else begin
         if (w_push) begin
            r_mem_addr[r_wr_ptr] <= bus.i_ll_addr;
            r_mem_data[r_wr_ptr] <= bus.i_ll_data;
            r_wr_ptr             <= r_wr_ptr + AW'(1);
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + AW'(1);
         end
         r_count <= w_count_nxt;
         r_wait  <= w_wait_nxt;
         // Stall is visible exactly in the cycle the wait counter sits at MAX_WAIT
         r_stall <= (w_wait_nxt == WAIT_MAX);

         if (w_pipe_req) begin
            r_write      <= 1'b1;
            r_write_addr <= bus.i_pipe_addr;
            r_write_data <= bus.i_pipe_data;
         end else if (w_pop) begin
            r_write      <= 1'b1;
            r_write_addr <= r_mem_addr[r_rd_ptr];
            r_write_data <= r_mem_data[r_rd_ptr];
         end else begin
            r_write <= 1'b0;
         end
      end
   end

   assign bus.o_pipe_stall = r_stall;
   assign bus.o_ll_ready   = w_ready;
   assign bus.o_write      = r_write;
   assign bus.o_write_addr = r_write_addr;
   assign bus.o_write_data = r_write_data;
   assign bus.o_fifo_count = r_count;
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Bench for regfile_wb_arbiter: per-cycle vector table plus hand-written full,
// starvation and reset sequences; expected writes flow through a scoreboard queue.
module tb_regfile_wb_arbiter;
   logic clk;
   logic rst_n;

   regfile_wb_arbiter_if #(.DEPTH(4)) bus ();

   regfile_wb_arbiter #(.DEPTH(4), .MAX_WAIT(8)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct packed {
      logic [4:0]  a;
      logic [31:0] d;
   } wr_t;

   typedef struct {
      logic        pv;
      logic [4:0]  pa;
      logic [31:0] pd;
      logic        lv;
      logic [4:0]  la;
      logic [31:0] ld;
      logic        ew;
      logic [4:0]  ea;
      logic [31:0] ed;
      logic [2:0]  ecnt;
      logic        erdy;
      logic        estl;
   } vec_t;

   wr_t  sb_q[$];
   vec_t vecs[12];
   int   n_total;
   int   n_pass;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act !== exp) begin
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end else begin
         n_pass++;
      end
   endtask

   task automatic drive(input logic pv, input logic [4:0] pa, input logic [31:0] pd,
                        input logic lv, input logic [4:0] la, input logic [31:0] ld);
      bus.i_pipe_valid = pv;
      bus.i_pipe_addr  = pa;
      bus.i_pipe_data  = pd;
      bus.i_ll_valid   = lv;
      bus.i_ll_addr    = la;
      bus.i_ll_data    = ld;
   endtask

   // One clock; every write must match the scoreboard head in that cycle
   task automatic step();
      wr_t e;
      @(posedge clk);
      #1;
      chk("write_en", 32'(bus.o_write), 32'(sb_q.size() != 0));
      if (sb_q.size() != 0) begin
         e = sb_q.pop_front();
         if (bus.o_write) begin
            chk("write_addr", 32'(bus.o_write_addr), 32'(e.a));
            chk("write_data", bus.o_write_data, e.d);
         end
      end
   endtask

   task automatic chk_status(input string tag, input int cnt, input logic rdy, input logic stl);
      chk({tag, "_count"}, 32'(bus.o_fifo_count), 32'(cnt));
      chk({tag, "_ready"}, 32'(bus.o_ll_ready), 32'(rdy));
      chk({tag, "_stall"}, 32'(bus.o_pipe_stall), 32'(stl));
   endtask

   initial begin
      n_total = 0;
      n_pass  = 0;
      rst_n   = 1'b0;
      drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);

      //            pv    pa     pd            lv    la     ld            ew    ea     ed            cnt   rdy   stl
      vecs[0]  = '{1'b1, 5'd5,  32'hDEADBEEF, 1'b0, 5'd0,  32'h0,       1'b1, 5'd5,  32'hDEADBEEF, 3'd0, 1'b1, 1'b0};
      vecs[1]  = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,       1'b0, 5'd0,  32'h0,        3'd0, 1'b1, 1'b0};
      vecs[2]  = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd3,  32'h11,      1'b0, 5'd0,  32'h0,        3'd1, 1'b1, 1'b0};
      vecs[3]  = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd4,  32'h22,      1'b1, 5'd3,  32'h11,       3'd1, 1'b1, 1'b0};
      vecs[4]  = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,       1'b1, 5'd4,  32'h22,       3'd0, 1'b1, 1'b0};
      vecs[5]  = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,       1'b0, 5'd0,  32'h0,        3'd0, 1'b1, 1'b0};
      vecs[6]  = '{1'b1, 5'd0,  32'h5555,     1'b1, 5'd0,  32'h6666,    1'b0, 5'd0,  32'h0,        3'd0, 1'b1, 1'b0};
      vecs[7]  = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd7,  32'h77,      1'b0, 5'd0,  32'h0,        3'd1, 1'b1, 1'b0};
      vecs[8]  = '{1'b1, 5'd0,  32'hAAAA,     1'b1, 5'd0,  32'hBBBB,    1'b1, 5'd7,  32'h77,       3'd0, 1'b1, 1'b0};
      vecs[9]  = '{1'b1, 5'd9,  32'h99,       1'b1, 5'd10, 32'hA0,      1'b1, 5'd9,  32'h99,       3'd1, 1'b1, 1'b0};
      vecs[10] = '{1'b1, 5'd11, 32'hB1,       1'b0, 5'd0,  32'h0,       1'b1, 5'd11, 32'hB1,       3'd1, 1'b1, 1'b0};
      vecs[11] = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,       1'b1, 5'd10, 32'hA0,       3'd0, 1'b1, 1'b0};

      repeat (2) @(posedge clk);
      #1;
      chk("rst_write", 32'(bus.o_write), 32'd0);
      chk("rst_addr", 32'(bus.o_write_addr), 32'd0);
      chk("rst_data", bus.o_write_data, 32'd0);
      chk_status("rst", 0, 1'b1, 1'b0);
      rst_n = 1'b1;

      for (int i = 0; i < 12; i++) begin
         drive(vecs[i].pv, vecs[i].pa, vecs[i].pd, vecs[i].lv, vecs[i].la, vecs[i].ld);
         if (vecs[i].ew) sb_q.push_back({vecs[i].ea, vecs[i].ed});
         step();
         chk_status($sformatf("vec%0d", i), int'(vecs[i].ecnt), vecs[i].erdy, vecs[i].estl);
      end

      // Fill to full with the pipeline busy; the head starves and forces a stall
      for (int c = 0; c < 16; c++) begin
         int k;
         int e;
         k = (c < 9) ? c : 9;
         e = (c < 4) ? c : 4;
         drive(c <= 10, 5'(k + 1), 32'hC000_0000 + 32'(k),
               c <= 10, 5'(20 + e), 32'hF000_0000 + 32'(20 + e));
         if (c <= 8)       sb_q.push_back({5'(c + 1), 32'hC000_0000 + 32'(c)});
         else if (c == 9)  sb_q.push_back({5'd20, 32'hF000_0014});
         else if (c == 10) sb_q.push_back({5'd10, 32'hC000_0009});
         else if (c <= 14) sb_q.push_back({5'(10 + c), 32'hF000_0000 + 32'(10 + c)});
         step();
         if (c == 3)            chk_status("full_c3", 4, 1'b0, 1'b0);
         if (c >= 4 && c <= 7)  chk_status($sformatf("held_c%0d", c), 4, 1'b0, 1'b0);
         if (c == 8)            chk_status("starve_c8", 4, 1'b0, 1'b1);
         if (c == 9)            chk_status("starve_pop_c9", 3, 1'b1, 1'b0);
         if (c == 10)           chk_status("refill_c10", 4, 1'b0, 1'b0);
         if (c == 14)           chk_status("drained_c14", 0, 1'b1, 1'b0);
      end

      // Queue three entries behind a busy pipeline, then reset mid-drain
      for (int c = 0; c < 3; c++) begin
         drive(1'b1, 5'(2 + c), 32'h5000_0000 + 32'(c), 1'b1, 5'(25 + c), 32'hE000_0000 + 32'(c));
         sb_q.push_back({5'(2 + c), 32'h5000_0000 + 32'(c)});
         step();
      end
      chk("pre_rst_count", 32'(bus.o_fifo_count), 32'd3);
      drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
      rst_n = 1'b0;
      #1;
      chk("mid_rst_write", 32'(bus.o_write), 32'd0);
      chk("mid_rst_addr", 32'(bus.o_write_addr), 32'd0);
      chk("mid_rst_data", bus.o_write_data, 32'd0);
      chk_status("mid_rst", 0, 1'b1, 1'b0);
      step();
      rst_n = 1'b1;
      for (int c = 0; c < 5; c++) step();
      chk_status("post_rst", 0, 1'b1, 1'b0);

      drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd12, 32'h1234);
      step();
      drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
      sb_q.push_back({5'd12, 32'h1234});
      step();
      chk_status("post_rst_drain", 0, 1'b1, 1'b0);
      step();

      chk("sb_empty", 32'(sb_q.size()), 32'd0);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
